// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [MD_XLEN-1:0] MD_DIV0_Q  = '1;
    localparam logic [MD_XLEN-1:0] MD_INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_PREP,
        MD_RUN,
        MD_FIX,
        MD_DONE
    } md_state_t;

    // funct3 bit 2 separates the divide family from the multiply family
    function automatic logic md_is_div(input md_op_t op);
        logic [2:0] bits;
        bits = op;
        return bits[2];
    endfunction

    function automatic logic md_is_rem(input md_op_t op);
        logic [2:0] bits;
        bits = op;
        return bits[1];
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// For divides, bit 0 of acc_out is left clear; q_bit supplies the new quotient bit.
module muldiv_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_out,
    output logic              q_bit
);

    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    assign hi = acc_in[2*XLEN-1:XLEN];
    assign lo = acc_in[XLEN-1:0];

    // A clear borrow bit in the (XLEN+1)-bit difference means the trial subtract fits
    always_comb begin
        sum     = {1'b0, hi} + {1'b0, operand};
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, operand};
        q_bit   = 1'b0;
        acc_out = '0;
        if (is_div) begin
            q_bit   = ~diff[XLEN];
            acc_out = {(q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0]), lo[XLEN-2:0], 1'b0};
        end else if (lo[0]) begin
            acc_out = {sum, lo[XLEN-1:1]};
        end else begin
            acc_out = {1'b0, hi, lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer that stalls the pipeline while it iterates.
// Define MULDIV_FAST_MUL_EN to compute multiplies with a single-cycle multiplier in PREP.
module ex_muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_e,
    input  logic [2:0]      muldiv_op_e,
    input  logic [XLEN-1:0] operand_a_e,
    input  logic [XLEN-1:0] operand_b_e,
    input  logic            flush_e,
    output logic            stall_md,
    output logic            result_valid,
    output logic [XLEN-1:0] md_result
);

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  DIV0_Q   = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);

    md_state_t         state_q, state_d;
    md_op_t            op_q;
    logic [XLEN-1:0]   a_q, b_q, mcand_q, md_result_q;
    logic [2*XLEN-1:0] acc_q, step_acc, prod_fix;
    logic [CNT_W-1:0]  cnt_q;
    logic              sign_a_q, sign_b_q;

    logic              is_div, is_rem, signed_a, signed_b, neg_a, neg_b;
    logic              div_by_zero, div_ovf, special, q_bit;
    logic [XLEN-1:0]   abs_a, abs_b, quot_fix, rem_fix, special_res, fix_res;

    assign is_div      = md_is_div(op_q);
    assign is_rem      = md_is_rem(op_q);
    assign signed_a    = (op_q == MD_MULH) || (op_q == MD_MULHSU) || (op_q == MD_DIV) || (op_q == MD_REM);
    assign signed_b    = (op_q == MD_MULH) || (op_q == MD_DIV) || (op_q == MD_REM);
    assign neg_a       = signed_a & a_q[XLEN-1];
    assign neg_b       = signed_b & b_q[XLEN-1];
    assign abs_a       = neg_a ? -a_q : a_q;
    assign abs_b       = neg_b ? -b_q : b_q;
    assign div_by_zero = is_div && (b_q == '0);
    assign div_ovf     = ((op_q == MD_DIV) || (op_q == MD_REM)) && (a_q == INT_MIN) && (b_q == DIV0_Q);
    assign special     = div_by_zero | div_ovf;

    muldiv_iter_step #(.XLEN(XLEN)) u_step (
        .acc_in  (acc_q),
        .operand (mcand_q),
        .is_div  (is_div),
        .acc_out (step_acc),
        .q_bit   (q_bit)
    );

    // Special-case divides bypass RUN/FIX, so their result is formed directly from the latched operands
    always_comb begin
        special_res = '0;
        if (div_by_zero) begin
            special_res = is_rem ? a_q : DIV0_Q;
        end else if (div_ovf) begin
            special_res = is_rem ? '0 : a_q;
        end
    end

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fix_res  = '0;
        case (op_q)
            MD_MUL:                       fix_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_res = quot_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stall_md     = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start_e && !flush_e) begin
                    state_d  = MD_PREP;
                    stall_md = reset_n;
                end
            end
            MD_PREP: begin
                stall_md = 1'b1;
                if (flush_e) begin
                    state_d = MD_IDLE;
                end else if (special) begin
                    state_d = MD_DONE;
                end else begin
`ifdef MULDIV_FAST_MUL_EN
                    state_d = is_div ? MD_RUN : MD_FIX;
`else
                    state_d = MD_RUN;
`endif
                end
            end
            MD_RUN: begin
                stall_md = 1'b1;
                if (flush_e) begin
                    state_d = MD_IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                stall_md = 1'b1;
                state_d  = flush_e ? MD_IDLE : MD_DONE;
            end
            MD_DONE: begin
                result_valid = 1'b1;
                state_d      = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // md_result only changes on an unflushed completion, so a killed op leaves the old value visible
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= MD_MUL;
            a_q         <= '0;
            b_q         <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            md_result_q <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start_e && !flush_e) begin
                        op_q <= md_op_t'(muldiv_op_e);
                        a_q  <= operand_a_e;
                        b_q  <= operand_b_e;
                    end
                end
                MD_PREP: begin
                    sign_a_q <= neg_a;
                    sign_b_q <= neg_b;
                    mcand_q  <= abs_b;
                    cnt_q    <= '0;
`ifdef MULDIV_FAST_MUL_EN
                    acc_q    <= is_div ? {{XLEN{1'b0}}, abs_a}
                                       : ({{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b});
`else
                    acc_q    <= {{XLEN{1'b0}}, abs_a};
`endif
                    if (special && !flush_e) begin
                        md_result_q <= special_res;
                    end
                end
                MD_RUN: begin
                    acc_q <= {step_acc[2*XLEN-1:1], step_acc[0] | q_bit};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                MD_FIX: begin
                    if (!flush_e) begin
                        md_result_q <= fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md_result = md_result_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed, table-driven bench for ex_muldiv_sequencer; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_ex_muldiv_sequencer;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = 35;
`endif
    localparam int DIV_LAT  = 35;
    localparam int SPC_LAT  = 2;
    localparam int NUM_VECS = 20;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_e = 1'b0;
    logic        flush_e = 1'b0;
    logic [2:0]  muldiv_op_e = 3'd0;
    logic [31:0] operand_a_e = '0;
    logic [31:0] operand_b_e = '0;
    logic        stall_md;
    logic        result_valid;
    logic [31:0] md_result;

    int checks_run = 0;
    int checks_passed = 0;
    vec_t vecs[NUM_VECS];

    ex_muldiv_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_e      (start_e),
        .muldiv_op_e  (muldiv_op_e),
        .operand_a_e  (operand_a_e),
        .operand_b_e  (operand_b_e),
        .flush_e      (flush_e),
        .stall_md     (stall_md),
        .result_valid (result_valid),
        .md_result    (md_result)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_run++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called just after a falling edge; that cycle is cycle 0. Returns -1 as latency if no pulse within 100 cycles.
    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output int stalls, output logic [31:0] res);
        int  cyc;
        bit  found;
        cyc    = 0;
        found  = 0;
        stalls = 0;
        lat    = -1;
        res    = 'x;
        start_e     = 1'b1;
        muldiv_op_e = op;
        operand_a_e = a;
        operand_b_e = b;
        while (!found && cyc < 100) begin
            #1;
            if (stall_md) stalls++;
            if (result_valid) begin
                found = 1;
                lat   = cyc;
                res   = md_result;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start_e = 1'b0;
    endtask

    initial begin
        int          lat, stalls, pulses;
        logic [31:0] res;
        logic [31:0] prev_res;

        vecs[0]  = '{"MUL 7*-3",          MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{"MULHU max*max",     MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[2]  = '{"MULH min*min",      MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vecs[3]  = '{"MULHSU -1*2",       MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT};
        vecs[4]  = '{"MUL 12*12",         MD_MUL,    32'd12,         32'd12,        32'd144,       MUL_LAT};
        vecs[5]  = '{"MULH -3*7",         MD_MULH,   32'hFFFF_FFFD,  32'd7,         32'hFFFF_FFFF, MUL_LAT};
        vecs[6]  = '{"MULH maxpos^2",     MD_MULH,   32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, MUL_LAT};
        vecs[7]  = '{"MUL -1*-1",         MD_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         MUL_LAT};
        vecs[8]  = '{"MULHSU 2*umax",     MD_MULHSU, 32'd2,          32'hFFFF_FFFF, 32'd1,         MUL_LAT};
        vecs[9]  = '{"DIV -7/2",          MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT};
        vecs[10] = '{"REM -7/2",          MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT};
        vecs[11] = '{"DIVU 100/7",        MD_DIVU,   32'd100,        32'd7,         32'd14,        DIV_LAT};
        vecs[12] = '{"REMU 100/7",        MD_REMU,   32'd100,        32'd7,         32'd2,         DIV_LAT};
        vecs[13] = '{"REM 7/-2",          MD_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         DIV_LAT};
        vecs[14] = '{"DIVU min/umax",     MD_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         DIV_LAT};
        vecs[15] = '{"DIVU 5/0",          MD_DIVU,   32'd5,          32'd0,         MD_DIV0_Q,     SPC_LAT};
        vecs[16] = '{"REM 5/0",           MD_REM,    32'd5,          32'd0,         32'd5,         SPC_LAT};
        vecs[17] = '{"DIV min/-1",        MD_DIV,    MD_INT_MIN,     32'hFFFF_FFFF, MD_INT_MIN,    SPC_LAT};
        vecs[18] = '{"REM min/-1",        MD_REM,    MD_INT_MIN,     32'hFFFF_FFFF, 32'd0,         SPC_LAT};
        vecs[19] = '{"REMU 7/0",          MD_REMU,   32'd7,          32'd0,         32'd7,         SPC_LAT};

        // Reset with a pending start: every output must stay low
        start_e = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_output("reset stall_md",     32'(stall_md),     32'd0);
        check_output("reset result_valid", 32'(result_valid), 32'd0);
        check_output("reset md_result",    md_result,         32'd0);
        start_e = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NUM_VECS; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, stalls, res);
            check_output({vecs[i].name, " result"},  res,         vecs[i].exp_res);
            check_output({vecs[i].name, " latency"}, 32'(lat),    32'(vecs[i].exp_lat));
            check_output({vecs[i].name, " stalls"},  32'(stalls), 32'(vecs[i].exp_lat));
        end
        prev_res = vecs[NUM_VECS-1].exp_res;

        // Flush a DIV in cycle 10, then start a MUL in cycle 11
        @(negedge clk);
        pulses      = 0;
        start_e     = 1'b1;
        muldiv_op_e = MD_DIV;
        operand_a_e = 32'd1000;
        operand_b_e = 32'd3;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (result_valid) pulses++;
            @(negedge clk);
        end
        start_e = 1'b0;
        flush_e = 1'b1;
        #1;
        if (result_valid) pulses++;
        @(negedge clk);
        flush_e = 1'b0;
        #1;
        check_output("flush stall low",   32'(stall_md),     32'd0);
        check_output("flush no valid",    32'(result_valid), 32'd0);
        check_output("flush pulse count", 32'(pulses),       32'd0);
        check_output("flush md_result",   md_result,         prev_res);
        apply_stimulus(MD_MUL, 32'd7, 32'hFFFF_FFFD, lat, stalls, res);
        check_output("post-flush MUL result",  res,      32'hFFFF_FFEB);
        check_output("post-flush MUL latency", 32'(lat), 32'(MUL_LAT));

        // Reset pulse in cycle 20 of a running divide
        @(negedge clk);
        start_e     = 1'b1;
        muldiv_op_e = MD_DIVU;
        operand_a_e = 32'd100;
        operand_b_e = 32'd7;
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_output("midreset stall_md",     32'(stall_md),     32'd0);
        check_output("midreset result_valid", 32'(result_valid), 32'd0);
        check_output("midreset md_result",    md_result,         32'd0);
        @(negedge clk);
        start_e = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        apply_stimulus(MD_DIVU, 32'd100, 32'd7, lat, stalls, res);
        check_output("post-reset DIVU result",  res,      32'd14);
        check_output("post-reset DIVU latency", 32'(lat), 32'(DIV_LAT));

        $display("%0d/%0d checks passed", checks_passed, checks_run);
        $finish;
    end

endmodule
